// File: rtl/log_mult_pkg.sv
// Shared widths, stage payload structs and the operand normaliser
// for the pipelined Mitchell log multiplier.
package log_mult_pkg;
  localparam int OP_W      = 16;
  localparam int K_W       = 4;
  localparam int FRAC_W    = 15;
  localparam int EXP_W     = 5;
  localparam int PROD_W    = 32;
  // The payload carries the widest supported tag; the top uses the low TAG_W bits.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [K_W-1:0]       k_a;
    logic [K_W-1:0]       k_b;
    logic [FRAC_W-1:0]    x_a;
    logic [FRAC_W-1:0]    x_b;
    logic                 zero;
    logic [TAG_MAX_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [EXP_W-1:0]     e;
    logic [FRAC_W-1:0]    f;
    logic                 zero;
    logic [TAG_MAX_W-1:0] tag;
  } s2_t;

  // Shift the leading one up to bit OP_W-1 and keep the bits below it.
  function automatic logic [FRAC_W-1:0] frac_of(input logic [OP_W-1:0] v,
                                                input logic [K_W-1:0] k);
    logic [OP_W-1:0] n;
    n = v << (K_W'(OP_W-1) - k);
    return n[FRAC_W-1:0];
  endfunction
endpackage

// File: rtl/hierarchical_lod_16bit.sv
// 16-bit leading-one detector built from four nibble detectors.
// k is the bit index of the leading one; zero flags an all-zero input.
module hierarchical_lod_16bit (
  input  logic [15:0] data,
  output logic [3:0]  k,
  output logic        zero
);
  logic [3:0]       nz;
  logic [3:0][1:0]  pos;

  for (genvar g = 0; g < 4; g++) begin : g_nib
    logic [3:0] n;
    assign n      = data[4*g +: 4];
    assign nz[g]  = |n;
    assign pos[g] = n[3] ? 2'd3 : n[2] ? 2'd2 : n[1] ? 2'd1 : 2'd0;
  end

  // Highest non-empty nibble wins; later iterations overwrite earlier ones.
  always_comb begin
    k    = '0;
    zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (nz[i]) begin
        k    = {2'(i), pos[i]};
        zero = 1'b0;
      end
    end
  end
endmodule

// File: rtl/mitchell_antilog.sv
// Antilog: rebuilds 1.f as a 1.15 mantissa and scales it by 2^e,
// dropping the 15 fraction bits (truncation, never rounds up).
module mitchell_antilog
  import log_mult_pkg::*;
(
  input  logic [EXP_W-1:0]  e,
  input  logic [FRAC_W-1:0] f,
  input  logic              zero,
  output logic [PROD_W-1:0] p
);
  logic [PROD_W+FRAC_W-1:0] w;

  assign w = {{(PROD_W-1){1'b0}}, 1'b1, f} << e;
  assign p = zero ? '0 : w[PROD_W+FRAC_W-1:FRAC_W];
endmodule

// File: rtl/mitchell_log_mult_pipe.sv
// 3-stage Mitchell log multiplier: normalise -> add logs -> antilog.
// One global enable stalls every stage together when the output is blocked.
module mitchell_log_mult_pipe
  import log_mult_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int STAGES = 3;

  logic [STAGES:1]   vld_pipe;
  logic              adv;
  logic [K_W-1:0]    k_a, k_b;
  logic              z_a, z_b;
  logic [FRAC_W:0]   fsum;
  logic [PROD_W-1:0] prod_d;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv & rst_n;

  hierarchical_lod_16bit u_lod_a (.data(in_a), .k(k_a), .zero(z_a));
  hierarchical_lod_16bit u_lod_b (.data(in_b), .k(k_b), .zero(z_b));

  always_comb begin
    s1_d                = '0;
    s1_d.k_a            = k_a;
    s1_d.k_b            = k_b;
    s1_d.x_a            = frac_of(in_a, k_a);
    s1_d.x_b            = frac_of(in_b, k_b);
    s1_d.zero           = z_a | z_b;
    s1_d.tag[TAG_W-1:0] = in_tag;
  end

  // A carry out of the fraction sum bumps the exponent by one.
  assign fsum = {1'b0, s1_q.x_a} + {1'b0, s1_q.x_b};

  always_comb begin
    s2_d      = '0;
    s2_d.e    = EXP_W'(s1_q.k_a) + EXP_W'(s1_q.k_b) + EXP_W'(fsum[FRAC_W]);
    s2_d.f    = fsum[FRAC_W-1:0];
    s2_d.zero = s1_q.zero;
    s2_d.tag  = s1_q.tag;
  end

  mitchell_antilog u_antilog (.e(s2_q.e), .f(s2_q.f), .zero(s2_q.zero), .p(prod_d));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (adv) begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], in_valid};
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_product <= prod_d;
      out_tag     <= s2_q.tag[TAG_W-1:0];
    end
  end
endmodule

// File: tb/tb_mitchell_log_mult_pipe.sv
// Bench for mitchell_log_mult_pipe: fixed vectors, streaming, stalls,
// bubbles and mid-flight reset against a log/antilog arithmetic model.
module tb_mitchell_log_mult_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] out_product;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;

  typedef struct { logic [31:0] p; logic [3:0] tag; } exp_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic [31:0] p; } vec_t;
  exp_t q[$];
  vec_t vt[6];

  mitchell_log_mult_pipe #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Mitchell: log2(v) ~ k + (v-2^k)/2^k; sum the logs, then 2^int * (1+frac).
  function automatic logic [31:0] mref(input int a, input int b);
    int     ka, kb;
    longint xa, xb, l, ip, fr, p;
    if (a == 0 || b == 0) return 32'd0;
    ka = 0; while ((a >> (ka + 1)) != 0) ka++;
    kb = 0; while ((b >> (kb + 1)) != 0) kb++;
    xa = ((longint'(a) - (longint'(1) << ka)) << 15) >> ka;
    xb = ((longint'(b) - (longint'(1) << kb)) << 15) >> kb;
    l  = (longint'(ka + kb) << 15) + xa + xb;
    ip = l >> 15;
    fr = l & 32767;
    p  = ((32768 + fr) << ip) >> 15;
    return p[31:0];
  endfunction

  // One clock: record transfers seen before the edge, then advance.
  task automatic step();
    exp_t e;
    #1;
    if (rst_n && in_valid && in_ready) begin
      q.push_back('{mref(int'(in_a), int'(in_b)), in_tag});
      n_in++;
    end
    if (out_valid && out_ready) begin
      n_out++;
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_product", out_product, e.p);
        chk("sb_tag", 32'(out_tag), 32'(e.tag));
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) q.delete();
  endtask

  task automatic drain(input int max);
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((q.size() != 0 || out_valid) && n < max) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Single item through an empty pipe: absent after 2 clk, present after 3.
  task automatic latency_check(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] tag, input logic [31:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1; in_a = a; in_b = b; in_tag = tag;
    step();
    in_valid  = 1'b0;
    step();
    chk({name, "_early"}, 32'(out_valid), 32'd0);
    step();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_prod"}, out_product, exp);
    chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    step();
  endtask

  initial begin
    logic [31:0] hold_p;
    logic [3:0]  hold_t;
    int          cnt, base_in, base_out;

    vt[0] = '{16'd1,     16'd1,    32'd1};
    vt[1] = '{16'd3,     16'd3,    32'd8};
    vt[2] = '{16'd5,     16'd7,    32'd32};
    vt[3] = '{16'd0,     16'd1234, 32'd0};
    vt[4] = '{16'd65535, 16'd65535, 32'hFFFE0000};
    vt[5] = '{16'd4096,  16'd256,  32'h00100000};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_a = 16'd9; in_b = 16'd9; in_tag = 4'd3;
    @(posedge clk); #1;

    // Reset held with input offered
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_product", out_product, 32'd0);
      chk("rst_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // Fixed vectors
    for (int i = 0; i < 6; i++)
      latency_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, 4'(i + 1), vt[i].p);

    // Streaming: 20 back-to-back pairs, one result per clock
    base_out  = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 23; i++) begin
      in_valid = (i < 20);
      in_a = 16'($urandom); in_b = 16'($urandom); in_tag = 4'(i % 16);
      step();
    end
    chk("stream_count", 32'(n_out - base_out), 32'd20);
    chk("stream_empty", 32'(q.size()), 32'd0);

    // Backpressure with the pipe full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom); in_tag = 4'(i + 8);
      step();
    end
    in_a = 16'd300; in_b = 16'd700; in_tag = 4'd11;
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    hold_p = out_product; hold_t = out_tag;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_prod", out_product, hold_p);
      chk("bp_hold_tag", 32'(out_tag), 32'(hold_t));
    end
    chk("bp_inflight", 32'(q.size()), 32'd3);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain(20);

    // Bubbles with random output acceptance
    base_in = n_in; base_out = n_out;
    for (int i = 0; i < 40; i++) begin
      in_valid  = ~i[0];
      in_a = 16'($urandom); in_b = 16'($urandom); in_tag = 4'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    drain(40);
    chk("bubble_count", 32'(n_out - base_out), 32'(n_in - base_in));

    // Reset with two items in flight
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 16'(100 + i); in_b = 16'd77; in_tag = 4'(i);
      step();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) cnt++;
    end
    chk("midrst_no_emit", 32'(cnt), 32'd0);
    latency_check("post_rst", 16'd1000, 16'd1000, 4'd5, mref(1000, 1000));
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule
